// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter: FSM states, port ids, default widths.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational; a lone requester wins, a tie goes to the port not served last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = ~last_grant;
    case (req)
      2'b01:   grant = PORT_IF;
      2'b10:   grant = PORT_D;
      default: grant = ~last_grant;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read RAM between fetch and load/store ports; ack 2 cycles after req, held until req drops.
// Optional MEM_ARB_RANGE_CHECK_EN: flag addresses above ADDR_W bits, suppress the RAM strobe and raise err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  state_t              state, state_nxt;
  logic                pick, load;
  logic                grant_q, last_grant, we_q, oor_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, if_rdata_q, d_rdata_q, cap_dat;
  logic [31:0]         sel_addr;
  logic                sel_oor;

  rr_arb2 u_rr (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign sel_addr = (pick == PORT_D) ? d_addr : if_addr;

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign sel_oor = |sel_addr[31:ADDR_W];
`else
  // Upper address bits are dropped so the address wraps onto the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = |sel_addr[31:ADDR_W];
  assign sel_oor        = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          load      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!oor_q) begin
          mem_write = we_q;
          mem_read  = ~we_q;
        end
        state_nxt = RESP;
      end
      RESP: begin
        if (grant_q == PORT_D) begin
          d_ack = 1'b1;
          if (!d_req) state_nxt = IDLE;
        end else begin
          if_ack = 1'b1;
          if (!if_req) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stores and flagged accesses return zero rather than whatever the RAM drives.
  assign cap_dat = (we_q || oor_q) ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      grant_q    <= PORT_IF;
      last_grant <= PORT_D;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (load) begin
        grant_q    <= pick;
        last_grant <= pick;
        addr_q     <= sel_addr[ADDR_W-1:0];
        oor_q      <= sel_oor;
        we_q       <= (pick == PORT_D) ? d_we : 1'b0;
        if (pick == PORT_D) wdata_q <= d_wdata;
      end
      if (state == ACCESS) begin
        if (grant_q == PORT_D) d_rdata_q  <= cap_dat;
        else                   if_rdata_q <= cap_dat;
      end
    end
  end

  assign mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q};
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = (state == RESP) && oor_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 512x32 RAM model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_read, mem_write, err;

  logic [31:0] ram [0:511];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[8:0]];
  always @(posedge clk) if (mem_write) ram[mem_addr[8:0]] = mem_wdata;

  mem_arbiter dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access on a port: raise req, wait for ack (bounded), drop req, sample ack one edge later.
  task automatic run_acc(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat,
                         output int nr, output int nw, output logic e, output logic oack,
                         output logic ack_after);
    logic got;
    if (port) begin d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1; end
    else begin if_addr = addr; if_req = 1'b1; end
    got = 1'b0; lat = 0; nr = 0; nw = 0; rd = '0; e = 1'b0; oack = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      if (mem_read)  nr++;
      if (mem_write) nw++;
      if (port ? d_ack : if_ack) begin
        got  = 1'b1;
        rd   = port ? d_rdata : if_rdata;
        e    = err;
        oack = port ? if_ack : d_ack;
      end
    end
    if (!got) lat = 99;
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    ack_after = port ? d_ack : if_ack;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, nr, nw, ovl, hold, got;
    logic        e, oack, ack_after;

    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    ram[9'h010] = 32'h0000_1234;
    ram[9'h011] = 32'h0000_A5A5;
    ram[9'h030] = 32'h0000_3030;
    ram[9'h000] = 32'hCAFE_0000;

    #2 clr = 1'b1;
    #1;
    chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    tick();
    clr = 1'b0;

    // Tie after reset: fetch wins first, then strict alternation.
    if_addr = 32'h10; d_addr = 32'h30; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    ovl = 0;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int i = 0; i < 10 && got < 0; i++) begin
        tick();
        if (mem_read && mem_write) ovl++;
        if (if_ack) got = 0;
        else if (d_ack) got = 1;
      end
      chk($sformatf("tie_order_%0d", k), got, k % 2);
      if (k == 0) chk("tie_if_rdata", if_rdata, 32'h1234);
      if (k == 1) chk("tie_d_rdata", d_rdata, 32'h3030);
      if (got == 0) if_req = 1'b0; else d_req = 1'b0;
      if (k == 3) begin if_req = 1'b0; d_req = 1'b0; end
      tick();
      if (mem_read && mem_write) ovl++;
      if (k < 3) begin
        if (got == 0) if_req = 1'b1; else d_req = 1'b1;
      end
    end
    tick();
    chk("tie_no_overlap", ovl, 32'd0);

    // Fetch only.
    run_acc(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, nr, nw, e, oack, ack_after);
    chk("fetch_latency", lat, 32'd2);
    chk("fetch_rdata", rd, 32'h1234);
    chk("fetch_reads", nr, 32'd1);
    chk("fetch_writes", nw, 32'd0);
    chk("fetch_d_ack_quiet", {31'b0, oack}, 32'd0);
    chk("fetch_ack_drop", {31'b0, ack_after}, 32'd0);

    // Store then load back.
    run_acc(1'b1, 1'b1, 32'h8E, 32'd9, rd, lat, nr, nw, e, oack, ack_after);
    chk("store_writes", nw, 32'd1);
    chk("store_reads", nr, 32'd0);
    chk("store_rdata_zero", rd, 32'd0);
    run_acc(1'b1, 1'b0, 32'h8E, 32'd0, rd, lat, nr, nw, e, oack, ack_after);
    chk("load_rdata", rd, 32'd9);
    chk("load_latency", lat, 32'd2);
    chk("load_if_ack_quiet", {31'b0, oack}, 32'd0);

    // Ack hold while req stays high.
    if_addr = 32'h11; if_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (if_ack) got = 1;
    end
    chk("hold_ack_seen", got, 32'd1);
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_ack) hold++;
    end
    chk("hold_ack_cycles", hold, 32'd4);
    chk("hold_rdata", if_rdata, 32'hA5A5);
    if_req = 1'b0;
    tick();
    chk("hold_ack_release", {31'b0, if_ack}, 32'd0);

    // Out-of-range data address.
    run_acc(1'b1, 1'b0, 32'h200, 32'h0, rd, lat, nr, nw, e, oack, ack_after);
`ifdef MEM_ARB_RANGE_CHECK_EN
    chk("range_rdata", rd, 32'd0);
    chk("range_err", {31'b0, e}, 32'd1);
    chk("range_reads", nr, 32'd0);
`else
    chk("range_rdata", rd, 32'hCAFE_0000);
    chk("range_err", {31'b0, e}, 32'd0);
    chk("range_reads", nr, 32'd1);
`endif
    chk("range_err_clear", {31'b0, err}, 32'd0);

    // Reset during a store's ACCESS cycle.
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; d_req = 1'b1;
    tick();
    chk("mid_store_strobe", {31'b0, mem_write}, 32'd1);
    clr = 1'b1;
    #1;
    chk("mid_rst_write", {31'b0, mem_write}, 32'd0);
    chk("mid_rst_read", {31'b0, mem_read}, 32'd0);
    chk("mid_rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_if_rdata", if_rdata, 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    clr = 1'b0;

    run_acc(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, nr, nw, e, oack, ack_after);
    chk("post_rst_latency", lat, 32'd2);
    chk("post_rst_rdata", rd, 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
